// File: rtl/ball_paddle_physics.sv
// Purpose: per-frame breakout game state (paddle, ball, lives, serve/over) for the renderer.
// Latency: registered outputs update on the clock edge that detects the FRAME_DONE rising edge.
// Backpressure: none; one update per FRAME_DONE rising edge, inputs sampled only at that strobe.
module ball_paddle_physics #(
    parameter int CEILING_Y_TILE      = 2,
    parameter int LEFT_WALL_X_TILE    = 2,
    parameter int RIGHT_WALL_X_TILE   = 97,
    parameter int PADDLE_Y_TILE       = 70,
    parameter int PADDLE_LENGTH_PIXEL = 64,
    parameter int BALL_SIZE_PIXEL     = 8,
    parameter int PADDLE_SPEED        = 4,
    parameter int BALL_SPEED          = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       FRAME_DONE,
    input  logic       BTN_LEFT,
    input  logic       BTN_RIGHT,
    input  logic       BTN_SERVE,
    output logic [9:0] PADDLE_X_PIXEL,
    output logic [9:0] BALL_X_PIXEL,
    output logic [9:0] BALL_Y_PIXEL,
    output logic [1:0] LIVES,
    output logic       BALL_LOST,
    output logic       GAME_OVER
);

    // Playfield edges in pixels
    localparam logic [9:0] L_X        = 10'((LEFT_WALL_X_TILE + 1) * 8);
    localparam logic [9:0] R_X        = 10'(RIGHT_WALL_X_TILE * 8);
    localparam logic [9:0] CEIL_Y     = 10'((CEILING_Y_TILE + 1) * 8);
    localparam logic [9:0] PAD_Y      = 10'(PADDLE_Y_TILE * 8);
    localparam logic [9:0] PAD_LEN    = 10'(PADDLE_LENGTH_PIXEL);
    localparam logic [9:0] BALL_SZ    = 10'(BALL_SIZE_PIXEL);
    localparam logic [9:0] PAD_SPD    = 10'(PADDLE_SPEED);
    localparam logic [9:0] BALL_SPD   = 10'(BALL_SPEED);
    localparam logic [9:0] PAD_MAX    = R_X - PAD_LEN;
    localparam logic [9:0] BALL_MAX_X = R_X - BALL_SZ;
    localparam logic [9:0] SERVE_OFS  = 10'((PADDLE_LENGTH_PIXEL - BALL_SIZE_PIXEL) / 2);
    localparam logic [9:0] SERVE_Y    = PAD_Y - BALL_SZ;
    localparam logic [9:0] LOSS_Y     = 10'd600;
    // Paddle starts centred between the walls, ball centred on it
    localparam logic [9:0] PAD_RST    = 10'((((LEFT_WALL_X_TILE + 1) * 8) + RIGHT_WALL_X_TILE * 8
                                             - PADDLE_LENGTH_PIXEL) / 2);
    localparam logic [9:0] BALL_X_RST = PAD_RST + SERVE_OFS;

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] left_sync, right_sync, serve_sync;
    logic       frame_prev;
    logic       strobe;
    logic       btn_l, btn_r, btn_s;

    logic [9:0] paddle_x, paddle_nxt;
    logic [9:0] ball_x, ball_x_nxt;
    logic [9:0] ball_y, ball_y_nxt;
    logic [1:0] lives, lives_nxt;
    logic       dx_pos, dx_nxt;     // 1: moving right
    logic       dy_down, dy_nxt;    // 1: moving down (towards the paddle)
    logic       lost, lost_nxt;
    logic [9:0] nx, ny;
    logic       hit;

    assign btn_l  = left_sync[1];
    assign btn_r  = right_sync[1];
    assign btn_s  = serve_sync[1];
    assign strobe = FRAME_DONE & ~frame_prev;

    // Two-flop synchronizers for the raw buttons and the frame edge detector history
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            left_sync  <= 2'b00;
            right_sync <= 2'b00;
            serve_sync <= 2'b00;
            frame_prev <= 1'b0;
        end else begin
            left_sync  <= {left_sync[0], BTN_LEFT};
            right_sync <= {right_sync[0], BTN_RIGHT};
            serve_sync <= {serve_sync[0], BTN_SERVE};
            frame_prev <= FRAME_DONE;
        end
    end

    // Next-state physics; everything holds unless the frame strobe fires
    always_comb begin
        state_nxt  = state;
        paddle_nxt = paddle_x;
        ball_x_nxt = ball_x;
        ball_y_nxt = ball_y;
        lives_nxt  = lives;
        dx_nxt     = dx_pos;
        dy_nxt     = dy_down;
        lost_nxt   = 1'b0;
        nx         = dx_pos  ? ball_x + BALL_SPD : ball_x - BALL_SPD;
        ny         = dy_down ? ball_y + BALL_SPD : ball_y - BALL_SPD;
        hit        = 1'b0;

        if (strobe) begin
            if (btn_l && !btn_r) begin
                paddle_nxt = (paddle_x < L_X + PAD_SPD) ? L_X : paddle_x - PAD_SPD;
            end else if (btn_r && !btn_l) begin
                paddle_nxt = (({1'b0, paddle_x} + {1'b0, PAD_SPD}) > {1'b0, PAD_MAX})
                             ? PAD_MAX : paddle_x + PAD_SPD;
            end

            case (state)
                S_SERVE: begin
                    ball_x_nxt = paddle_nxt + SERVE_OFS;
                    ball_y_nxt = SERVE_Y;
                    if (btn_s) begin
                        state_nxt = S_PLAY;
                        dx_nxt    = 1'b1;
                        dy_nxt    = 1'b0;
                    end
                end
                S_PLAY: begin
                    if (nx < L_X) begin
                        nx     = L_X;
                        dx_nxt = 1'b1;
                    end else if (({1'b0, nx} + {1'b0, BALL_SZ}) > {1'b0, R_X}) begin
                        nx     = BALL_MAX_X;
                        dx_nxt = 1'b0;
                    end
                    if (ny < CEIL_Y) begin
                        ny     = CEIL_Y;
                        dy_nxt = 1'b1;
                    end
                    // Paddle test uses the paddle position from before this frame's move
                    hit = dy_down
                        && (({1'b0, ball_y} + {1'b0, BALL_SZ}) <= {1'b0, PAD_Y})
                        && (({1'b0, ny} + {1'b0, BALL_SZ}) > {1'b0, PAD_Y})
                        && (({1'b0, nx} + {1'b0, BALL_SZ}) > {1'b0, paddle_x})
                        && ({1'b0, nx} < ({1'b0, paddle_x} + {1'b0, PAD_LEN}));
                    if (hit) begin
                        ny     = SERVE_Y;
                        dy_nxt = 1'b0;
                    end
                    ball_x_nxt = nx;
                    ball_y_nxt = ny;
                    if (!hit && (ny >= LOSS_Y)) begin
                        lost_nxt  = 1'b1;
                        lives_nxt = lives - 2'd1;
                        dx_nxt    = 1'b1;
                        dy_nxt    = 1'b0;
                        state_nxt = (lives == 2'd1) ? S_OVER : S_SERVE;
                    end
                end
                S_OVER: begin
                    if (btn_s) begin
                        lives_nxt = 2'd3;
                        state_nxt = S_SERVE;
                    end
                end
                default: state_nxt = S_SERVE;
            endcase
        end
    end

    // Game state registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_SERVE;
            paddle_x <= PAD_RST;
            ball_x   <= BALL_X_RST;
            ball_y   <= SERVE_Y;
            lives    <= 2'd3;
            dx_pos   <= 1'b1;
            dy_down  <= 1'b0;
            lost     <= 1'b0;
        end else begin
            state    <= state_nxt;
            paddle_x <= paddle_nxt;
            ball_x   <= ball_x_nxt;
            ball_y   <= ball_y_nxt;
            lives    <= lives_nxt;
            dx_pos   <= dx_nxt;
            dy_down  <= dy_nxt;
            lost     <= lost_nxt;
        end
    end

    assign PADDLE_X_PIXEL = paddle_x;
    assign BALL_X_PIXEL   = ball_x;
    assign BALL_Y_PIXEL   = ball_y;
    assign LIVES          = lives;
    assign BALL_LOST      = lost;
    assign GAME_OVER      = (state == S_OVER);

endmodule
